// File: rtl/sram_arbiter_pkg.sv
// Shared constants and types for the SRAM arbiter: reset level, memory
// direction encoding, stall encoding and the arbiter FSM state encoding.
package sram_arbiter_pkg;

    localparam logic RST_ENABLE = 1'b0;

    typedef logic mem_rw_t;
    localparam mem_rw_t MEM_RW_READ  = 1'b0;
    localparam mem_rw_t MEM_RW_WRITE = 1'b1;

    localparam logic STALL_YES = 1'b1;
    localparam logic STALL_NO  = 1'b0;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: fetch port, data port and the
// per-port stall requests toward the pipeline controller.
//
// Handshake: a requester raises *_req as a level and holds it, with its
// address/data, until it sees *_ack. *_ack is a one-cycle pulse and the
// matching *_rdata is valid only in that cycle. Values presented after the
// grant are ignored; the arbiter works from its latched copy.
interface sram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    import sram_arbiter_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              mem_req;
    mem_rw_t           mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic              stall_req_if;
    logic              stall_req_mem;

    // Pipeline side: issues requests, receives data, acks and stalls.
    modport master (
        output if_req, if_addr, mem_req, mem_rw, mem_addr, mem_wdata,
        input  if_rdata, if_ack, mem_rdata, mem_ack, stall_req_if, stall_req_mem
    );

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, mem_req, mem_rw, mem_addr, mem_wdata,
        output if_rdata, if_ack, mem_rdata, mem_ack, stall_req_if, stall_req_mem
    );

endinterface

// File: rtl/sram_arbiter.sv
// Single-port asynchronous SRAM arbiter. MEM has priority over IF; each
// transaction is IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE (ack) -> IDLE.
// All SRAM strobes, acks and read data are registered; strobes are computed
// from the next-state values so they line up with the state they belong to.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 3,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    sram_arbiter_if.slave     bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wdata_oe,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output arb_state_e        dbg_state
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    arb_owner_e        owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    mem_rw_t           rw_q, rw_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              mem_ack_q, mem_ack_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_wdata_oe_q, ram_wdata_oe_d;
    logic              ram_ce_n_q, ram_ce_n_d;
    logic              ram_oe_n_q, ram_oe_n_d;
    logic              ram_we_n_q, ram_we_n_d;
    logic              in_access;

    // Next-state, latch and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (bus.mem_req) begin
                    owner_d = OWN_MEM;
                    addr_d  = bus.mem_addr;
                    rw_d    = bus.mem_rw;
                    wdata_d = bus.mem_wdata;
                    cnt_d   = CNT_ONE;
                    state_d = ARB_ACCESS;
                end else if (bus.if_req) begin
                    owner_d = OWN_IF;
                    addr_d  = bus.if_addr;
                    rw_d    = MEM_RW_READ;
                    cnt_d   = CNT_ONE;
                    state_d = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    state_d = ARB_DONE;
                    if (owner_q == OWN_MEM) begin
                        mem_ack_d = 1'b1;
                        if (rw_q == MEM_RW_READ) mem_rdata_d = ram_rdata;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = ram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            // Requests are deliberately not sampled here.
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase

        // The write pulse sits strictly inside the access window so address
        // and data are stable for at least one cycle on either side.
        in_access      = (state_d == ARB_ACCESS);
        ram_addr_d     = in_access ? addr_d : ram_addr_q;
        ram_wdata_d    = (in_access && rw_d == MEM_RW_WRITE) ? wdata_d : ram_wdata_q;
        ram_wdata_oe_d = in_access && (rw_d == MEM_RW_WRITE);
        ram_ce_n_d     = !in_access;
        ram_oe_n_d     = !(in_access && rw_d == MEM_RW_READ);
        ram_we_n_d     = !(in_access && rw_d == MEM_RW_WRITE &&
                           cnt_d > CNT_ONE && cnt_d < CNT_MAX);
    end

    // FSM and all registered outputs; reset drops any in-flight access.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q        <= ARB_IDLE;
            cnt_q          <= '0;
            owner_q        <= OWN_IF;
            addr_q         <= '0;
            rw_q           <= MEM_RW_READ;
            wdata_q        <= '0;
            if_rdata_q     <= '0;
            mem_rdata_q    <= '0;
            if_ack_q       <= 1'b0;
            mem_ack_q      <= 1'b0;
            ram_addr_q     <= '0;
            ram_wdata_q    <= '0;
            ram_wdata_oe_q <= 1'b0;
            ram_ce_n_q     <= 1'b1;
            ram_oe_n_q     <= 1'b1;
            ram_we_n_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            owner_q        <= owner_d;
            addr_q         <= addr_d;
            rw_q           <= rw_d;
            wdata_q        <= wdata_d;
            if_rdata_q     <= if_rdata_d;
            mem_rdata_q    <= mem_rdata_d;
            if_ack_q       <= if_ack_d;
            mem_ack_q      <= mem_ack_d;
            ram_addr_q     <= ram_addr_d;
            ram_wdata_q    <= ram_wdata_d;
            ram_wdata_oe_q <= ram_wdata_oe_d;
            ram_ce_n_q     <= ram_ce_n_d;
            ram_oe_n_q     <= ram_oe_n_d;
            ram_we_n_q     <= ram_we_n_d;
        end
    end

    assign bus.if_rdata      = if_rdata_q;
    assign bus.if_ack        = if_ack_q;
    assign bus.mem_rdata     = mem_rdata_q;
    assign bus.mem_ack       = mem_ack_q;
    assign bus.stall_req_if  = (rst != RST_ENABLE && bus.if_req && !if_ack_q)
                               ? STALL_YES : STALL_NO;
    assign bus.stall_req_mem = (rst != RST_ENABLE && bus.mem_req && !mem_ack_q)
                               ? STALL_YES : STALL_NO;

    assign ram_addr     = ram_addr_q;
    assign ram_wdata    = ram_wdata_q;
    assign ram_wdata_oe = ram_wdata_oe_q;
    assign ram_ce_n     = ram_ce_n_q;
    assign ram_oe_n     = ram_oe_n_q;
    assign ram_we_n     = ram_we_n_q;
    assign dbg_state    = state_q;

endmodule
